serial_word_loader: RTL and testbench

Upstream feeder for the sequential ones-counter stage. It assembles a serial bit stream into data_width-bit words, MSB first, and presents each word on a valid/ack handshake. After acknowledgement it holds the word stable for hold_cycles clocks so the downstream counter can finish evaluating it. A one-word park buffer lets the next word finish filling while the output is busy; bits offered with no room are dropped and flagged.

---
 rtl/serial_word_loader_if.sv | 26 ++
 rtl/serial_word_loader.sv | 158 +++++++++++++++
 tb/tb_serial_word_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_loader_if.sv
// Bundles the serial-input and word-output handshake signals of the loader.
//   bit_in / bit_valid / bit_ready : serial bit stream into the loader
//   word_out / word_valid / word_ack : assembled word handshake to the consumer
//   overrun : sticky flag for bits offered while the loader was full
// slave modport: the loader side.  master modport: the feeder/consumer side.
interface serial_word_loader_if #(
  parameter int data_width = 4
) ();
  logic                  bit_in;
  logic                  bit_valid;
  logic                  bit_ready;
  logic [data_width-1:0] word_out;
  logic                  word_valid;
  logic                  word_ack;
  logic                  overrun;

  modport slave (
    input  bit_in, bit_valid, word_ack,
    output bit_ready, word_out, word_valid, overrun
  );

  modport master (
    output bit_in, bit_valid, word_ack,
    input  bit_ready, word_out, word_valid, overrun
  );
endinterface

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader feeding the sequential ones-counter stage.
// Bits arrive MSB first and are assembled into data_width-bit words. A word
// is presented on word_out/word_valid until word_ack, then held stable for
// hold_cycles clocks. One completed word can park in the shift register while
// the output is busy; bits offered with no room are dropped and set overrun.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : serial_word_loader_if.slave (bit stream in, word handshake out)
module serial_word_loader #(
  parameter int data_width  = 4,
  parameter int hold_cycles = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_word_loader_if.slave  bus
);

  localparam int cnt_w  = (data_width  > 1) ? $clog2(data_width)      : 1;
  localparam int hold_w = (hold_cycles > 1) ? $clog2(hold_cycles + 1) : 1;

  localparam logic [cnt_w-1:0]  last_bit_idx = cnt_w'(data_width - 1);
  localparam logic [hold_w-1:0] hold_load    = hold_w'(hold_cycles);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [data_width-1:0]  shreg_r;
  logic [cnt_w-1:0]       bit_cnt_r;
  logic                   pending_r;
  logic [data_width-1:0]  word_r;
  logic                   word_valid_r;
  logic [hold_w-1:0]      hold_cnt_r;
  logic [hold_w-1:0]      hold_next_s;
  logic                   overrun_r;

  logic                   accept_s;
  logic                   word_done_s;
  logic [data_width-1:0]  shreg_shift_s;
  logic                   load_s;
  logic [data_width-1:0]  load_word_s;
  logic                   pending_next_s;

  // A parked word blocks further input until it moves to the output.
  assign accept_s      = bus.bit_valid & ~pending_r;
  assign shreg_shift_s = {shreg_r[data_width-2:0], bus.bit_in};
  assign word_done_s   = accept_s & (bit_cnt_r == last_bit_idx);

  assign bus.bit_ready  = ~pending_r;
  assign bus.word_out   = word_r;
  assign bus.word_valid = word_valid_r;
  assign bus.overrun    = overrun_r;

  // Output FSM next-state, word load selection and hold countdown.
  always_comb begin
    state_next_s = state_r;
    hold_next_s  = hold_cnt_r;
    load_s       = 1'b0;
    load_word_s  = shreg_r;
    case (state_r)
      ST_IDLE: begin
        // A parked word has priority; no bit can be accepted while parked.
        if (pending_r) begin
          load_s       = 1'b1;
          load_word_s  = shreg_r;
          state_next_s = ST_VALID;
        end else if (word_done_s) begin
          load_s       = 1'b1;
          load_word_s  = shreg_shift_s;
          state_next_s = ST_VALID;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_VALID: begin
        if (bus.word_ack) begin
          if (hold_cycles == 0) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_HOLD;
            hold_next_s  = hold_load;
          end
        end else begin
          state_next_s = ST_VALID;
        end
      end
      ST_HOLD: begin
        // Leaving on a count of 1 makes HOLD last exactly hold_cycles clocks.
        hold_next_s = hold_cnt_r - hold_w'(1);
        if (hold_cnt_r == hold_w'(1)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        hold_next_s  = {hold_w{1'b0}};
      end
    endcase
  end

  // Park buffer occupancy: set when a word completes while the output is busy.
  always_comb begin
    pending_next_s = pending_r;
    if (word_done_s && (state_r != ST_IDLE)) begin
      pending_next_s = 1'b1;
    end else if ((state_r == ST_IDLE) && pending_r) begin
      pending_next_s = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Input side: shift register and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_r   <= {data_width{1'b0}};
      bit_cnt_r <= {cnt_w{1'b0}};
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (accept_s) begin
        shreg_r <= shreg_shift_s;
        if (bit_cnt_r == last_bit_idx) begin
          bit_cnt_r <= {cnt_w{1'b0}};
        end else begin
          bit_cnt_r <= bit_cnt_r + cnt_w'(1);
        end
      end
      pending_r <= pending_next_s;
      overrun_r <= overrun_r | (bus.bit_valid & pending_r);
    end
  end

  // Output side: FSM state, hold counter, word register and registered valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= {hold_w{1'b0}};
      word_r       <= {data_width{1'b0}};
      word_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      hold_cnt_r   <= hold_next_s;
      word_valid_r <= (state_next_s == ST_VALID);
      if (load_s) begin
        word_r <= load_word_s;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader. Two instances: hold_cycles=4 (a)
// and hold_cycles=0 (b). Expected words go into per-instance queues when
// sent and are popped whenever word_valid rises; word_out must not change
// at any other time.
module tb_serial_word_loader;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic       prev_a, prev_b;
  logic [3:0] last_a, last_b;

  serial_word_loader_if #(.data_width(4)) bus_a ();
  serial_word_loader_if #(.data_width(4)) bus_b ();

  serial_word_loader #(.data_width(4), .hold_cycles(4)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  serial_word_loader #(.data_width(4), .hold_cycles(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and run the word scoreboards.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus_a.word_valid === 1'b1 && prev_a !== 1'b1) begin
      tests++;
      assert (q_a.size() != 0) else begin
        fails++;
        $error("FAIL a_unexpected_word observed=%0h expected=none", bus_a.word_out);
      end
      if (q_a.size() != 0) check("a_word", {28'd0, bus_a.word_out}, {28'd0, q_a.pop_front()});
    end else begin
      check("a_word_stable", {28'd0, bus_a.word_out}, {28'd0, last_a});
    end
    if (bus_b.word_valid === 1'b1 && prev_b !== 1'b1) begin
      tests++;
      assert (q_b.size() != 0) else begin
        fails++;
        $error("FAIL b_unexpected_word observed=%0h expected=none", bus_b.word_out);
      end
      if (q_b.size() != 0) check("b_word", {28'd0, bus_b.word_out}, {28'd0, q_b.pop_front()});
    end else begin
      check("b_word_stable", {28'd0, bus_b.word_out}, {28'd0, last_b});
    end
    prev_a = bus_a.word_valid;
    prev_b = bus_b.word_valid;
    last_a = bus_a.word_out;
    last_b = bus_b.word_out;
  endtask

  task automatic send_a(input logic b);
    bus_a.bit_in    = b;
    bus_a.bit_valid = 1'b1;
    cycle();
    bus_a.bit_valid = 1'b0;
  endtask

  task automatic send_b(input logic b);
    bus_b.bit_in    = b;
    bus_b.bit_valid = 1'b1;
    cycle();
    bus_b.bit_valid = 1'b0;
  endtask

  task automatic send_word_a(input logic [3:0] w);
    q_a.push_back(w);
    for (int i = 3; i >= 0; i--) send_a(w[i]);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_valid"},   {31'd0, bus_a.word_valid}, 32'd0);
    check({tag, "_word"},    {28'd0, bus_a.word_out},   32'd0);
    check({tag, "_overrun"}, {31'd0, bus_a.overrun},    32'd0);
    check({tag, "_ready"},   {31'd0, bus_a.bit_ready},  32'd1);
    check({tag, "_b_valid"}, {31'd0, bus_b.word_valid}, 32'd0);
    check({tag, "_b_word"},  {28'd0, bus_b.word_out},   32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    prev_a = 1'b0; prev_b = 1'b0;
    last_a = 4'h0; last_b = 4'h0;
    reset = 1'b0;
    bus_a.bit_in = 1'b0; bus_a.bit_valid = 1'b0; bus_a.word_ack = 1'b0;
    bus_b.bit_in = 1'b0; bus_b.bit_valid = 1'b0; bus_b.word_ack = 1'b0;
    repeat (2) cycle();
    check_zero_a("reset");
    reset = 1'b1;
    cycle();

    // 1: word of ones, valid one clock after the 4th bit.
    send_word_a(4'hF);
    check("t1_valid", {31'd0, bus_a.word_valid}, 32'd1);
    check("t1_ready", {31'd0, bus_a.bit_ready},  32'd1);
    bus_a.word_ack = 1'b1; cycle(); bus_a.word_ack = 1'b0;
    check("t1_valid_after_ack", {31'd0, bus_a.word_valid}, 32'd0);
    repeat (5) cycle();

    // 2: long wait before ack, then word held through HOLD.
    send_word_a(4'hA);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t2_valid_wait", {31'd0, bus_a.word_valid}, 32'd1);
    end
    bus_a.word_ack = 1'b1; cycle(); bus_a.word_ack = 1'b0;
    check("t2_valid_after_ack", {31'd0, bus_a.word_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t2_hold_word", {28'd0, bus_a.word_out}, 32'hA);
    end
    repeat (2) cycle();

    // 3: back-to-back words with immediate ack; second word parks.
    bus_a.word_ack = 1'b1;
    send_word_a(4'h5);
    send_word_a(4'hB);
    check("t3_ready_parked", {31'd0, bus_a.bit_ready},  32'd0);
    check("t3_valid_hold",   {31'd0, bus_a.word_valid}, 32'd0);
    check("t3_overrun",      {31'd0, bus_a.overrun},    32'd0);
    cycle();
    check("t3_ready_idle",   {31'd0, bus_a.bit_ready},  32'd0);
    cycle();
    check("t3_valid_xfer",   {31'd0, bus_a.word_valid}, 32'd1);
    check("t3_ready_xfer",   {31'd0, bus_a.bit_ready},  32'd1);
    cycle();
    bus_a.word_ack = 1'b0;
    repeat (5) cycle();

    // 3b: word completes on the very edge HOLD exits; it parks then transfers.
    send_word_a(4'hD);
    bus_a.word_ack = 1'b1; cycle(); bus_a.word_ack = 1'b0;
    send_word_a(4'hE);
    check("t3b_valid_exit", {31'd0, bus_a.word_valid}, 32'd0);
    check("t3b_ready_exit", {31'd0, bus_a.bit_ready},  32'd0);
    cycle();
    check("t3b_valid_xfer", {31'd0, bus_a.word_valid}, 32'd1);
    bus_a.word_ack = 1'b1; cycle(); bus_a.word_ack = 1'b0;
    repeat (5) cycle();

    // 4: overrun while parked; parked word and bit count survive.
    send_word_a(4'h3);
    send_word_a(4'h6);
    check("t4_ready_parked", {31'd0, bus_a.bit_ready}, 32'd0);
    check("t4_overrun_pre",  {31'd0, bus_a.overrun},   32'd0);
    bus_a.bit_in = 1'b1; bus_a.bit_valid = 1'b1; cycle(); bus_a.bit_valid = 1'b0;
    check("t4_overrun_set",  {31'd0, bus_a.overrun},   32'd1);
    repeat (3) cycle();
    check("t4_overrun_sticky", {31'd0, bus_a.overrun}, 32'd1);
    bus_a.word_ack = 1'b1; cycle(); bus_a.word_ack = 1'b0;
    repeat (5) cycle();
    check("t4_parked_valid", {31'd0, bus_a.word_valid}, 32'd1);
    send_word_a(4'hC);
    bus_a.word_ack = 1'b1; cycle(); bus_a.word_ack = 1'b0;
    repeat (5) cycle();
    check("t4_next_valid", {31'd0, bus_a.word_valid}, 32'd1);
    bus_a.word_ack = 1'b1; cycle(); bus_a.word_ack = 1'b0;
    repeat (5) cycle();
    check("t4_overrun_final", {31'd0, bus_a.overrun}, 32'd1);

    // 5: reset mid-fill discards the partial word.
    send_a(1'b1);
    send_a(1'b0);
    reset = 1'b0;
    bus_a.bit_in = 1'b1; bus_a.bit_valid = 1'b1;
    #1;
    last_a = 4'h0; prev_a = 1'b0; last_b = 4'h0; prev_b = 1'b0;
    check_zero_a("t5_in_reset");
    cycle();
    check_zero_a("t5_reset_cycle");
    reset = 1'b1; bus_a.bit_valid = 1'b0;
    send_word_a(4'h9);
    check("t5_valid", {31'd0, bus_a.word_valid}, 32'd1);
    bus_a.word_ack = 1'b1; cycle(); bus_a.word_ack = 1'b0;
    repeat (5) cycle();

    // 6: hold_cycles=0 instance, ack held high, no HOLD cycles.
    bus_b.word_ack = 1'b1;
    q_b.push_back(4'hC);
    send_b(1'b1); send_b(1'b1); send_b(1'b0); send_b(1'b0);
    check("t6_valid_c", {31'd0, bus_b.word_valid}, 32'd1);
    q_b.push_back(4'h0);
    send_b(1'b0);
    check("t6_idle_after_ack", {31'd0, bus_b.word_valid}, 32'd0);
    check("t6_word_kept",      {28'd0, bus_b.word_out},   32'hC);
    send_b(1'b0); send_b(1'b0); send_b(1'b0);
    check("t6_valid_0", {31'd0, bus_b.word_valid}, 32'd1);
    check("t6_ready",   {31'd0, bus_b.bit_ready},  32'd1);
    cycle();
    check("t6_idle_end", {31'd0, bus_b.word_valid}, 32'd0);
    bus_b.word_ack = 1'b0;
    repeat (2) cycle();

    check("a_sb_drained", q_a.size(), 32'd0);
    check("b_sb_drained", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
